// File: rtl/i2s_tx_fifo_param.sv
// rtl/i2s_tx_fifo_param.sv - FIFO-buffered stereo DAC serialiser (I2S, left- and right-justified)
// Frames are popped into shadow registers at each left-slot start; BCLK is divided from clk_in.
module i2s_tx_fifo_param #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                frame_start,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] B_LAST   = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] RJ_OFF   = BW'(SLOT_W - SAMPLE_W);
  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic [1:0]              rst_sync_q;
  logic                    rst_ni;
  logic [2*SAMPLE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  state_t                  state_q;
  logic [DW-1:0]           div_q;
  logic [BW-1:0]           bit_q;
  logic                    bclk_q, lrck_q, dat_q, lj_prev_q;
  logic                    frame_start_q, underrun_q;
  logic [SAMPLE_W-1:0]     left_q, right_q;
  logic [1:0]              mode_q;
  logic [7:0]              urun_cnt_q;

  logic                    push, pop, fall, wrap, boundary, load, empty;
  logic [2*SAMPLE_W-1:0]   head;
  logic [BW-1:0]           bit_d;
  logic                    lrck_d, lj_d, direct_d, dat_d;
  logic [SAMPLE_W-1:0]     left_d, right_d, slot_x;
  logic [1:0]              mode_d;

  // Bit of sample x at slot position p, left-justified or right-justified.
  function automatic logic serial_bit(input logic [SAMPLE_W-1:0] x, input logic [BW-1:0] p,
                                      input logic rj);
    logic [SAMPLE_W-1:0] sh;
    if (rj) sh = (p >= RJ_OFF) ? (x << (p - RJ_OFF)) : '0;
    else    sh = x << p;
    return sh[SAMPLE_W-1];
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  always_comb begin
    empty    = (count_q == '0);
    s_ready  = (count_q != CNT_FULL);
    push     = s_valid && s_ready;
    fall     = (state_q == ST_RUN) && bclk_q && (div_q == D_LAST);
    wrap     = fall && (bit_q == B_LAST);
    boundary = wrap && lrck_q;
    load     = enable && ((state_q == ST_IDLE) || boundary);
    pop      = load && !empty;
    head     = mem_q[rd_ptr_q];
    left_d   = load ? (pop ? head[2*SAMPLE_W-1:SAMPLE_W] : '0) : left_q;
    right_d  = load ? (pop ? head[SAMPLE_W-1:0] : '0) : right_q;
    mode_d   = load ? mode : mode_q;
    bit_d    = ((state_q == ST_IDLE) || wrap) ? '0 : bit_q + 1'b1;
    lrck_d   = (state_q == ST_IDLE) ? 1'b0 : (wrap ? ~lrck_q : lrck_q);
    slot_x   = lrck_d ? right_d : left_d;
    lj_d     = serial_bit(slot_x, bit_d, 1'b0);
    direct_d = serial_bit(slot_x, bit_d, mode_d == 2'd2);
    // I2S (and reserved mode) replays the previous left-justified bit: one BCLK of delay.
    dat_d    = (mode_d == 2'd1 || mode_d == 2'd2) ? direct_d : lj_prev_q;
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {s_left, s_right};
  end

  always_ff @(posedge clk_in or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      dat_q         <= 1'b0;
      lj_prev_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      mode_q        <= 2'd0;
      urun_cnt_q    <= 8'd0;
    end else begin
      frame_start_q <= load;
      underrun_q    <= load && empty;
      if (load && empty && urun_cnt_q != 8'hFF) urun_cnt_q <= urun_cnt_q + 8'd1;
      if (load) begin
        left_q  <= left_d;
        right_q <= right_d;
        mode_q  <= mode_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q   <= ST_RUN;
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_q     <= bit_d;
            lrck_q    <= lrck_d;
            dat_q     <= dat_d;
            lj_prev_q <= lj_d;
          end
        end
        default: begin
          if (div_q == D_LAST) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
          end else begin
            div_q <= div_q + 1'b1;
          end
          if (boundary && !enable) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_q     <= '0;
            lrck_q    <= 1'b0;
            dat_q     <= 1'b0;
            lj_prev_q <= 1'b0;
          end else if (fall) begin
            bit_q     <= bit_d;
            lrck_q    <= lrck_d;
            dat_q     <= dat_d;
            lj_prev_q <= lj_d;
          end
        end
      endcase
    end
  end

  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = urun_cnt_q;
endmodule

// File: tb/tb_i2s_tx_fifo_param.sv
// tb/tb_i2s_tx_fifo_param.sv - directed scoreboard bench for i2s_tx_fifo_param
// Three instances: 16/32 main, 24-bit right-justified, and a tiny one for fast counter saturation.
module tb_i2s_tx_fifo_param;
  typedef struct packed { logic dat; logic lrck; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode = 2'd1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic m_en = 1'b0, m_valid = 1'b0, m_ready;
  logic [15:0] m_left = '0, m_right = '0;
  logic m_bclk, m_lrck, m_dat, m_fs, m_ur;
  logic [7:0] m_cnt;

  logic r_en = 1'b0, r_valid = 1'b0, r_ready;
  logic [23:0] r_left = '0, r_right = '0;
  logic r_bclk, r_lrck, r_dat, r_fs, r_ur;
  logic [7:0] r_cnt;

  logic t_en = 1'b0, t_valid = 1'b0, t_ready;
  logic [1:0] t_left = '0, t_right = '0;
  logic t_bclk, t_lrck, t_dat, t_fs, t_ur;
  logic [7:0] t_cnt;

  logic sel = 1'b0;
  logic obs_bclk, obs_lrck, obs_dat, obs_fs, obs_ur, obs_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    obs_bclk  = sel ? r_bclk  : m_bclk;
    obs_lrck  = sel ? r_lrck  : m_lrck;
    obs_dat   = sel ? r_dat   : m_dat;
    obs_fs    = sel ? r_fs    : m_fs;
    obs_ur    = sel ? r_ur    : m_ur;
    obs_ready = sel ? r_ready : m_ready;
  end

  i2s_tx_fifo_param #(.CLK_DIV(2), .SAMPLE_W(16), .SLOT_W(32), .FIFO_DEPTH(4)) dut (
    .clk_in(clk), .rst_n(rst_n), .enable(m_en), .mode(mode), .s_valid(m_valid),
    .s_ready(m_ready), .s_left(m_left), .s_right(m_right), .AUD_BCLK(m_bclk),
    .AUD_DACLRCK(m_lrck), .AUD_DACDAT(m_dat), .frame_start(m_fs), .underrun(m_ur),
    .underrun_cnt(m_cnt));

  i2s_tx_fifo_param #(.CLK_DIV(2), .SAMPLE_W(24), .SLOT_W(32), .FIFO_DEPTH(4)) dut_rj (
    .clk_in(clk), .rst_n(rst_n), .enable(r_en), .mode(mode), .s_valid(r_valid),
    .s_ready(r_ready), .s_left(r_left), .s_right(r_right), .AUD_BCLK(r_bclk),
    .AUD_DACLRCK(r_lrck), .AUD_DACDAT(r_dat), .frame_start(r_fs), .underrun(r_ur),
    .underrun_cnt(r_cnt));

  i2s_tx_fifo_param #(.CLK_DIV(1), .SAMPLE_W(2), .SLOT_W(2), .FIFO_DEPTH(2)) dut_tiny (
    .clk_in(clk), .rst_n(rst_n), .enable(t_en), .mode(mode), .s_valid(t_valid),
    .s_ready(t_ready), .s_left(t_left), .s_right(t_right), .AUD_BCLK(t_bclk),
    .AUD_DACLRCK(t_lrck), .AUD_DACDAT(t_dat), .frame_start(t_fs), .underrun(t_ur),
    .underrun_cnt(t_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot-format reference: m=1 left-justified, m=2 right-justified, 32-bit slots.
  function automatic logic fbit(input logic [23:0] x, input int sw, input int b, input int m);
    logic [23:0] t;
    if (m == 2) begin
      if (b < 32 - sw) return 1'b0;
      t = x >> (31 - b);
    end else begin
      if (b >= sw) return 1'b0;
      t = x >> (sw - 1 - b);
    end
    return t[0];
  endfunction

  // Expected 64 bits of one frame that starts from IDLE.
  task automatic build_frame(input logic [23:0] l, input logic [23:0] r, input int sw, input int m);
    for (int p = 0; p < 64; p++) begin
      logic d;
      if (m == 1 || m == 2) d = fbit((p < 32) ? l : r, sw, p % 32, m);
      else if (p == 0)      d = 1'b0;
      else                  d = fbit(((p - 1) < 32) ? l : r, sw, (p - 1) % 32, 1);
      sb.push_back('{dat: d, lrck: (p >= 32)});
    end
  endtask

  task automatic collect(output int t_first, output int t_last);
    logic prev;
    exp_t e;
    int n, idx;
    prev = obs_bclk; n = 0; idx = 0; t_first = -1; t_last = -1;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (obs_bclk && !prev) begin
        e = sb.pop_front();
        if (idx == 0) t_first = cyc;
        t_last = cyc;
        chk($sformatf("dat_bit%0d", idx), 32'(obs_dat), 32'(e.dat));
        chk($sformatf("lrck_bit%0d", idx), 32'(obs_lrck), 32'(e.lrck));
        idx++;
      end
      prev = obs_bclk;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_frame(input logic s, input logic [1:0] m, input logic [23:0] l,
                           input logic [23:0] r, input int sw);
    int t0, t1;
    sel = s; mode = m;
    build_frame(l, r, sw, int'(m == 2'd3 ? 2'd0 : m));
    if (!s) begin m_left = l[15:0]; m_right = r[15:0]; m_valid = 1'b1; end
    else    begin r_left = l; r_right = r; r_valid = 1'b1; end
    chk("ready_before_push", 32'(obs_ready), 32'd1);
    @(negedge clk);
    m_valid = 1'b0; r_valid = 1'b0;
    if (!s) m_en = 1'b1; else r_en = 1'b1;
    @(negedge clk);
    chk("frame_start", 32'(obs_fs), 32'd1);
    chk("no_underrun", 32'(obs_ur), 32'd0);
    m_en = 1'b0; r_en = 1'b0;
    collect(t0, t1);
    chk("bclk_63_periods", 32'(t1 - t0), 32'd252);
    repeat (12) @(negedge clk);
    chk("idle_lines", 32'({obs_bclk, obs_lrck, obs_dat}), 32'd0);
  endtask

  initial begin
    int fs, ur, acc, rises;
    int t0, t1;
    logic dor, prev;
    repeat (5) @(negedge clk);
    chk("rst_ready", 32'(m_ready), 32'd1);
    chk("rst_lines", 32'({m_bclk, m_lrck, m_dat, m_fs, m_ur}), 32'd0);
    chk("rst_cnt", 32'(m_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_lines", 32'({m_bclk, m_lrck, m_dat}), 32'd0);

    run_frame(1'b0, 2'd1, 24'h00A5C3, 24'h008001, 16);
    run_frame(1'b0, 2'd0, 24'h00A5C3, 24'h008001, 16);
    run_frame(1'b1, 2'd2, 24'h800001, 24'hC00003, 24);
    sel = 1'b0;

    mode = 2'd1; m_en = 1'b1; fs = 0; ur = 0; dor = 1'b0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (m_fs) fs++;
      if (m_ur) ur++;
      dor = dor | m_dat;
      if (fs == 3) m_en = 1'b0;
    end
    chk("urun_frames", 32'(fs), 32'd3);
    chk("urun_pulses", 32'(ur), 32'd3);
    chk("urun_cnt", 32'(m_cnt), 32'd3);
    chk("urun_dat_zero", 32'(dor), 32'd0);

    t_en = 1'b1; ur = 0;
    for (int c = 0; c < 4000 && ur < 300; c++) begin
      @(negedge clk);
      if (t_ur) begin
        ur++;
        if (ur == 100) chk("sat_cnt_100", 32'(t_cnt), 32'd100);
      end
    end
    t_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("sat_pulses", 32'(ur), 32'd300);
    chk("sat_cnt", 32'(t_cnt), 32'd255);

    acc = 0; m_valid = 1'b1; m_left = 16'h1000; m_right = 16'h2000;
    for (int c = 0; c < 6; c++) begin
      if (m_ready) acc++;
      @(negedge clk);
      m_left = 16'h1000 + 16'(acc); m_right = 16'h2000 + 16'(acc);
    end
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_ready_low", 32'(m_ready), 32'd0);
    m_en = 1'b1; acc = 0; rises = 0; prev = m_bclk;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("hs_frame_start", 32'(m_fs), 32'd1);
        m_en = 1'b0;
      end
      if (m_valid && m_ready) acc++;
      if (c == 8) m_valid = 1'b0;
      if (m_bclk && !prev) rises++;
      prev = m_bclk;
    end
    chk("hs_one_after_pop", 32'(acc), 32'd1);
    chk("hs_frame_rises", 32'(rises), 32'd64);
    chk("hs_idle_lines", 32'({m_bclk, m_lrck, m_dat}), 32'd0);
    chk("hs_ready_full", 32'(m_ready), 32'd0);

    mode = 2'd1;
    build_frame(24'h001001, 24'h002001, 16, 1);
    m_en = 1'b1;
    @(negedge clk);
    chk("order_frame_start", 32'(m_fs), 32'd1);
    collect(t0, t1);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_lines", 32'({m_bclk, m_lrck, m_dat, m_fs, m_ur}), 32'd0);
    chk("midrst_ready", 32'(m_ready), 32'd1);
    chk("midrst_cnt", 32'(m_cnt), 32'd0);
    m_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
